// File: rtl/imm_ext_stage_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings and
// a helper that tells which encodings produce a defined result.
package imm_ext_stage_pkg;

   localparam logic [2:0] MODE_ZERO16 = 3'd0;
   localparam logic [2:0] MODE_SIGN16 = 3'd1;
   localparam logic [2:0] MODE_LUI    = 3'd2;
   localparam logic [2:0] MODE_JUMP26 = 3'd3;
   localparam logic [2:0] MODE_BRANCH = 3'd4;
   localparam logic [2:0] MODE_RAW26  = 3'd5;

   function automatic logic mode_is_legal(input logic [2:0] mode);
      return (mode <= MODE_RAW26);
   endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension / jump and branch target formation.
// Undefined modes yield zero data with the illegal flag raised.
module imm_ext_core
   import imm_ext_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        mode,
   input  logic [15:0]       imm16,
   input  logic [25:0]       imm26,
   input  logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] data,
   output logic              illegal
);

   logic [DATA_W-1:0] pc4;
   logic [DATA_W-1:0] zext16;
   logic [DATA_W-1:0] sext16;
   logic [DATA_W-1:0] lui_val;
   logic [DATA_W-1:0] jump_val;
   logic [DATA_W-1:0] branch_val;
   logic [DATA_W-1:0] raw26_val;

   assign pc4        = pc + DATA_W'(4);
   assign zext16     = {{(DATA_W-16){1'b0}}, imm16};
   assign sext16     = {{(DATA_W-16){imm16[15]}}, imm16};
   assign jump_val   = {pc4[DATA_W-1:28], imm26, 2'b00};
   assign branch_val = pc4 + (sext16 << 2);
   assign raw26_val  = {{(DATA_W-26){1'b0}}, imm26};

   // LUI is a 32-bit result; wider datapaths see it sign-extended.
   generate
      if (DATA_W > 32) begin : g_lui_wide
         assign lui_val = {{(DATA_W-32){imm16[15]}}, imm16, 16'h0000};
      end else begin : g_lui_narrow
         assign lui_val = {imm16, 16'h0000};
      end
   endgenerate

   always_comb begin
      data    = '0;
      illegal = !mode_is_legal(mode);
      case (mode)
         MODE_ZERO16: data = zext16;
         MODE_SIGN16: data = sext16;
         MODE_LUI:    data = lui_val;
         MODE_JUMP26: data = jump_val;
         MODE_BRANCH: data = branch_val;
         MODE_RAW26:  data = raw26_val;
         default:     data = '0;
      endcase
   end

endmodule

// File: rtl/imm_ext_stage.sv
// Immediate-extension stage: extends on entry, then buffers results in a
// small non-bypassable FIFO with valid/ready on both sides and a flush.
module imm_ext_stage #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter int TAG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_mode,
   input  logic [15:0]       in_imm16,
   input  logic [25:0]       in_imm26,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_illegal
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] ext_data;
   logic              ext_illegal;

   imm_ext_core #(.DATA_W(DATA_W)) u_core (
      .mode    (in_mode),
      .imm16   (in_imm16),
      .imm26   (in_imm26),
      .pc      (in_pc),
      .data    (ext_data),
      .illegal (ext_illegal)
   );

   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [TAG_W-1:0]  tag_mem  [DEPTH];
   logic              ill_mem  [DEPTH];

   logic [PTR_W-1:0] wptr_reg, wptr_next;
   logic [PTR_W-1:0] rptr_reg, rptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             push, pop;

   // Ready depends on registered occupancy only, never on out_ready.
   assign in_ready  = (count_reg != FULL_CNT);
   assign out_valid = (count_reg != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_comb begin
      wptr_next  = wptr_reg;
      rptr_next  = rptr_reg;
      count_next = count_reg;
      if (flush) begin
         wptr_next  = '0;
         rptr_next  = '0;
         count_next = '0;
      end else begin
         if (push) wptr_next = wptr_reg + 1'b1;
         if (pop)  rptr_next = rptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         count_reg <= '0;
      end else begin
         wptr_reg  <= wptr_next;
         rptr_reg  <= rptr_next;
         count_reg <= count_next;
      end
   end

   // Storage is cleared on reset so the head reads as zero until first write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_mem[i] <= '0;
            tag_mem[i]  <= '0;
            ill_mem[i]  <= 1'b0;
         end
      end else if (push) begin
         data_mem[wptr_reg] <= ext_data;
         tag_mem[wptr_reg]  <= in_tag;
         ill_mem[wptr_reg]  <= ext_illegal;
      end
   end

   assign out_data    = data_mem[rptr_reg];
   assign out_tag     = tag_mem[rptr_reg];
   assign out_illegal = ill_mem[rptr_reg];

endmodule

// File: tb/tb_imm_ext_stage.sv
// Scoreboard bench for imm_ext_stage: a 32-bit instance under handshake,
// backpressure, flush and reset traffic, plus a 64-bit instance for LUI/branch.
module tb_imm_ext_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;

   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid, out_illegal;
   logic [2:0]  in_mode = '0;
   logic [15:0] in_imm16 = '0;
   logic [25:0] in_imm26 = '0;
   logic [31:0] in_pc = '0;
   logic [4:0]  in_tag = '0;
   logic [31:0] out_data;
   logic [4:0]  out_tag;

   logic        in_valid64 = 1'b0, out_ready64 = 1'b0;
   logic        in_ready64, out_valid64, out_illegal64;
   logic [2:0]  in_mode64 = '0;
   logic [15:0] in_imm16_64 = '0;
   logic [25:0] in_imm26_64 = '0;
   logic [63:0] in_pc64 = '0;
   logic [4:0]  in_tag64 = '0;
   logic [63:0] out_data64;
   logic [4:0]  out_tag64;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] d;
      logic [4:0]  t;
      logic        il;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] cur_exp_data = '0;
   logic        cur_exp_ill = 1'b0;

   always #5 clk = ~clk;

   imm_ext_stage #(.DATA_W(32), .DEPTH(2), .TAG_W(5)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_imm16(in_imm16), .in_imm26(in_imm26), .in_pc(in_pc), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_illegal(out_illegal)
   );

   imm_ext_stage #(.DATA_W(64), .DEPTH(2), .TAG_W(5)) u_dut64 (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(in_valid64), .in_ready(in_ready64), .in_mode(in_mode64),
      .in_imm16(in_imm16_64), .in_imm26(in_imm26_64), .in_pc(in_pc64), .in_tag(in_tag64),
      .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64),
      .out_tag(out_tag64), .out_illegal(out_illegal64)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference for 32-bit results, written from the mode definitions.
   function automatic logic [31:0] ref32(input logic [2:0] m, input logic [15:0] i16,
                                         input logic [25:0] i26, input logic [31:0] pc);
      logic [31:0] nxt;
      logic [31:0] sx;
      nxt = pc + 32'd4;
      sx  = {{16{i16[15]}}, i16};
      case (m)
         3'd0:    return {16'h0000, i16};
         3'd1:    return sx;
         3'd2:    return {i16, 16'h0000};
         3'd3:    return {nxt[31:28], i26, 2'b00};
         3'd4:    return nxt + {sx[29:0], 2'b00};
         3'd5:    return {6'b0, i26};
         default: return 32'h0;
      endcase
   endfunction

   // Handshakes are decided by signals stable between the drive point and the next edge.
   always @(negedge clk) begin
      if (rst || flush) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check_val("sb_underflow", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               $display("pop  data=%h tag=%0d ill=%0b (exp %h/%0d/%0b)",
                        out_data, out_tag, out_illegal, e.d, e.t, e.il);
               check_val("pop_data", 64'(out_data), 64'(e.d));
               check_val("pop_tag", 64'(out_tag), 64'(e.t));
               check_val("pop_ill", 64'(out_illegal), 64'(e.il));
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back('{d: cur_exp_data, t: in_tag, il: cur_exp_ill});
            $display("push mode=%0d tag=%0d exp=%h", in_mode, in_tag, cur_exp_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] m, input logic [15:0] i16, input logic [25:0] i26,
                        input logic [31:0] pc, input logic [4:0] tg,
                        input logic [31:0] exp_d, input logic exp_il);
      in_valid     = 1'b1;
      in_mode      = m;
      in_imm16     = i16;
      in_imm26     = i26;
      in_pc        = pc;
      in_tag       = tg;
      cur_exp_data = exp_d;
      cur_exp_ill  = exp_il;
   endtask

   task automatic drive_ref(input logic [2:0] m, input logic [15:0] i16, input logic [25:0] i26,
                            input logic [31:0] pc, input logic [4:0] tg);
      drive(m, i16, i26, pc, tg, ref32(m, i16, i26, pc), m > 3'd5);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] mode_exp [8];

   initial begin
      mode_exp[0] = 32'h0000_8001; mode_exp[1] = 32'hFFFF_8001;
      mode_exp[2] = 32'h8001_0000; mode_exp[3] = 32'h4FFF_FFFC;
      mode_exp[4] = 32'h3FFE_0108; mode_exp[5] = 32'h03FF_FFFF;
      mode_exp[6] = 32'h0;         mode_exp[7] = 32'h0;

      // Reset state
      tick(); tick();
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_out_data", 64'(out_data), 64'd0);
      check_val("rst_out_tag", 64'(out_tag), 64'd0);
      check_val("rst_out_ill", 64'(out_illegal), 64'd0);
      rst = 1'b0;
      tick();
      check_val("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Single push, one-cycle latency
      out_ready = 1'b1;
      drive(3'd1, 16'hFFF0, 26'h0, 32'h0, 5'd3, 32'hFFFF_FFF0, 1'b0);
      tick();
      in_valid = 1'b0;
      check_val("single_out_valid", 64'(out_valid), 64'd1);
      check_val("single_out_data", 64'(out_data), 64'hFFFF_FFF0);
      tick();
      check_val("single_drained", 64'(out_valid), 64'd0);

      // All modes, streaming with out_ready held high
      for (int m = 0; m < 8; m++) begin
         drive(3'(m), 16'h8001, 26'h3FF_FFFF, 32'h4000_0100, 5'(m + 8), mode_exp[m], m >= 6);
         tick();
      end
      in_valid = 1'b0;
      tick();
      check_val("modes_drained", 64'(out_valid), 64'd0);

      // Backpressure: fill, attempt a third, then drain in order
      out_ready = 1'b0;
      drive_ref(3'd0, 16'h00AA, 26'h0, 32'h0, 5'd20);
      tick();
      drive_ref(3'd1, 16'h00BB, 26'h0, 32'h0, 5'd21);
      tick();
      check_val("bp_full_in_ready", 64'(in_ready), 64'd0);
      drive_ref(3'd0, 16'h00CC, 26'h0, 32'h0, 5'd22);
      tick(); tick();
      check_val("bp_hold_valid", 64'(out_valid), 64'd1);
      check_val("bp_hold_data", 64'(out_data), 64'h0000_00AA);
      check_val("bp_hold_in_ready", 64'(in_ready), 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check_val("bp_ready_after_pop", 64'(in_ready), 64'd1);
      tick();
      check_val("bp_drained", 64'(out_valid), 64'd0);

      // Simultaneous push/pop at count=1
      out_ready = 1'b0;
      drive_ref(3'd4, 16'h0010, 26'h0, 32'h1000_0000, 5'd1);
      tick();
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive_ref(3'($urandom_range(0, 7)), 16'($urandom), 26'($urandom), $urandom, 5'(k));
         tick();
         check_val("pp_out_valid", 64'(out_valid), 64'd1);
         check_val("pp_in_ready", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;
      tick();
      check_val("pp_drained", 64'(out_valid), 64'd0);

      // Flush with two queued and a same-cycle input
      out_ready = 1'b0;
      drive_ref(3'd0, 16'h1111, 26'h0, 32'h0, 5'd5);
      tick();
      drive_ref(3'd0, 16'h2222, 26'h0, 32'h0, 5'd6);
      tick();
      drive_ref(3'd0, 16'hDEAD, 26'h0, 32'h0, 5'd31);
      out_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check_val("flush_out_valid", 64'(out_valid), 64'd0);
      check_val("flush_in_ready", 64'(in_ready), 64'd1);
      tick(); tick();
      check_val("flush_no_ghost", 64'(out_valid), 64'd0);

      // Asynchronous reset with two entries queued
      out_ready = 1'b0;
      drive_ref(3'd1, 16'h7777, 26'h0, 32'h0, 5'd9);
      tick();
      drive_ref(3'd1, 16'h8888, 26'h0, 32'h0, 5'd10);
      tick();
      in_valid = 1'b0;
      check_val("arst_pre_valid", 64'(out_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check_val("arst_out_valid", 64'(out_valid), 64'd0);
      check_val("arst_out_data", 64'(out_data), 64'd0);
      check_val("arst_in_ready", 64'(in_ready), 64'd1);
      #3 rst = 1'b0;
      tick();
      out_ready = 1'b1;
      tick();
      check_val("arst_stays_empty", 64'(out_valid), 64'd0);
      check_val("sb_empty", 64'(sb_q.size()), 64'd0);

      // 64-bit instance: LUI sign extension, then branch across 4 GiB
      in_valid64  = 1'b1;
      in_mode64   = 3'd2;
      in_imm16_64 = 16'h8000;
      in_tag64    = 5'd7;
      tick();
      check_val("w64_lui_valid", 64'(out_valid64), 64'd1);
      check_val("w64_lui_data", out_data64, 64'hFFFF_FFFF_8000_0000);
      check_val("w64_lui_tag", 64'(out_tag64), 64'd7);
      in_mode64   = 3'd4;
      in_imm16_64 = 16'hFFFF;
      in_pc64     = 64'h0000_0001_0000_0000;
      in_tag64    = 5'd8;
      out_ready64 = 1'b1;
      tick();
      in_valid64 = 1'b0;
      check_val("w64_br_data", out_data64, 64'h0000_0001_0000_0000);
      check_val("w64_br_tag", 64'(out_tag64), 64'd8);
      tick();
      check_val("w64_drained", 64'(out_valid64), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
